sonar_rx_decoder: RTL

SONAR_RX_DECODER -- requirements
Module: sonar_rx_decoder

---
 rtl/sonar_rx_decoder.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sonar_rx_decoder.sv
// Serial receiver (7E2) plus "AAA,DDDD#" frame parser for the sonar link.
// Define SONAR_RX_PARITY_EN to turn the even-parity check into a frame error.
module sonar_rx_decoder #(
   parameter int CLK_DIV = 434
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        entrada_serial,
   output logic [11:0] angulo,
   output logic [15:0] distancia,
   output logic        pronto,
   output logic        erro,
   output logic [3:0]  db_estado
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

   typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARIDADE, PARADA1, PARADA2} rx_st_t;
   typedef enum logic [3:0] {ANG0, ANG1, ANG2, VIRG, DIS0, DIS1, DIS2, DIS3, FIM, RESYNC} ps_t;

   logic          sync1_q, sync2_q, prev_q;
   rx_st_t        rx_st_q, rx_st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [6:0]    shr_q, shr_d;
   logic          perr_q, perr_d;
   logic          stb_q, stb_d, ferr_q, ferr_d;
   logic          rx, smp;

   assign rx  = sync2_q;
   assign smp = (cnt_q == FULL);

   // ---------------- receiver: state register ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         rx_st_q <= OCIOSO;
         cnt_q   <= '0;
         bit_q   <= '0;
         shr_q   <= '0;
         perr_q  <= 1'b0;
         stb_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= entrada_serial;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         rx_st_q <= rx_st_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shr_q   <= shr_d;
         perr_q  <= perr_d;
         stb_q   <= stb_d;
         ferr_q  <= ferr_d;
      end
   end

   // ---------------- receiver: next state ----------------
   // After a framing error the line may still be low; OCIOSO only leaves on a
   // 1->0 edge, so it implicitly waits for the line to return high first.
   always_comb begin
      rx_st_d = rx_st_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shr_d   = shr_q;
      perr_d  = perr_q;
      case (rx_st_q)
         OCIOSO: begin
            cnt_d = '0;
            bit_d = '0;
            if (prev_q && !rx) rx_st_d = INICIO;
         end
         INICIO: if (cnt_q == HALF) begin
            cnt_d   = '0;
            rx_st_d = rx ? OCIOSO : DADOS;
         end
         DADOS: if (smp) begin
            cnt_d = '0;
            shr_d = {rx, shr_q[6:1]};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd6) rx_st_d = PARIDADE;
         end
         PARIDADE: if (smp) begin
            cnt_d   = '0;
`ifdef SONAR_RX_PARITY_EN
            perr_d  = ^{shr_q, rx};
`endif
            rx_st_d = PARADA1;
         end
         PARADA1: if (smp) begin
            cnt_d   = '0;
            rx_st_d = rx ? PARADA2 : OCIOSO;
         end
         PARADA2: if (smp) begin
            cnt_d   = '0;
            rx_st_d = OCIOSO;
         end
         default: rx_st_d = OCIOSO;
      endcase
   end

   // ---------------- receiver: outputs (character strobe) ----------------
   always_comb begin
      stb_d  = 1'b0;
      ferr_d = 1'b0;
      if (smp && rx_st_q == PARADA1 && !rx) begin
         stb_d  = 1'b1;
         ferr_d = 1'b1;
      end
      if (smp && rx_st_q == PARADA2) begin
         stb_d  = 1'b1;
         ferr_d = !rx;
      end
   end

   // ---------------- parser ----------------
   ps_t         ps_q, ps_d;
   logic [11:0] ang_sh_q, ang_sh_d, ang_q, ang_d;
   logic [15:0] dis_sh_q, dis_sh_d, dis_q, dis_d;
   logic        pronto_q, pronto_d, erro_q, erro_d;
   logic [7:0]  ch;
   logic        is_dig, class_ok;

   assign ch     = {1'b0, shr_q};
   assign is_dig = (ch >= 8'h30) && (ch <= 8'h39);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ps_q     <= ANG0;
         ang_sh_q <= '0;
         dis_sh_q <= '0;
         ang_q    <= '0;
         dis_q    <= '0;
         pronto_q <= 1'b0;
         erro_q   <= 1'b0;
      end else begin
         ps_q     <= ps_d;
         ang_sh_q <= ang_sh_d;
         dis_sh_q <= dis_sh_d;
         ang_q    <= ang_d;
         dis_q    <= dis_d;
         pronto_q <= pronto_d;
         erro_q   <= erro_d;
      end
   end

   always_comb begin
      case (ps_q)
         VIRG:    class_ok = (ch == 8'h2C);
         FIM:     class_ok = (ch == 8'h23);
         RESYNC:  class_ok = 1'b0;
         default: class_ok = is_dig;
      endcase
   end

   always_comb begin
      ps_d     = ps_q;
      ang_sh_d = ang_sh_q;
      dis_sh_d = dis_sh_q;
      ang_d    = ang_q;
      dis_d    = dis_q;
      pronto_d = 1'b0;
      erro_d   = 1'b0;
      if (stb_q) begin
         if (ps_q == RESYNC) begin
            if (!ferr_q && !perr_q && ch == 8'h23) ps_d = ANG0;
         end else if (ferr_q || perr_q || !class_ok) begin
            ps_d     = RESYNC;
            erro_d   = 1'b1;
            ang_sh_d = '0;
            dis_sh_d = '0;
         end else begin
            case (ps_q)
               ANG0: begin ang_sh_d[11:8]  = ch[3:0]; ps_d = ANG1; end
               ANG1: begin ang_sh_d[7:4]   = ch[3:0]; ps_d = ANG2; end
               ANG2: begin ang_sh_d[3:0]   = ch[3:0]; ps_d = VIRG; end
               VIRG: ps_d = DIS0;
               DIS0: begin dis_sh_d[15:12] = ch[3:0]; ps_d = DIS1; end
               DIS1: begin dis_sh_d[11:8]  = ch[3:0]; ps_d = DIS2; end
               DIS2: begin dis_sh_d[7:4]   = ch[3:0]; ps_d = DIS3; end
               DIS3: begin dis_sh_d[3:0]   = ch[3:0]; ps_d = FIM;  end
               default: begin
                  ang_d    = ang_sh_q;
                  dis_d    = dis_sh_q;
                  pronto_d = 1'b1;
                  ps_d     = ANG0;
               end
            endcase
         end
      end
   end

   assign angulo    = ang_q;
   assign distancia = dis_q;
   assign pronto    = pronto_q;
   assign erro      = erro_q;
   assign db_estado = ps_q;

endmodule
